// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline (load-use, EXE jumps, bounded MEM waits).
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] exe_rd_addr,
    input  logic                  exe_mem_read,
    input  logic                  exe_jump_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_exe_stall,
    output logic                  id_exe_flush,
    output logic                  exe_mem_stall,
    output logic                  exe_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  pc_jump_sel,
    output logic                  mem_timeout_err,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          timeout, mem_wait, jump, load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout)
                mem_timeout_err <= 1'b1;
        end
    end

    // wait_cnt is always 0 in RUN, so entering MEM_WAIT loads 1
    always_comb begin
        timeout      = state == MEM_WAIT && wait_cnt == CW'(MEM_TIMEOUT) && dmem_req && !dmem_ready;
        mem_wait     = dmem_req && !dmem_ready && !timeout;
        jump         = exe_jump_taken && !mem_wait;
        load_use     = !mem_wait && !jump && exe_mem_read && exe_rd_addr != '0 &&
                       ((id_rs1_used && id_rs1_addr == exe_rd_addr) ||
                        (id_rs2_used && id_rs2_addr == exe_rd_addr));
        state_nxt    = mem_wait ? MEM_WAIT : RUN;
        wait_cnt_nxt = mem_wait ? wait_cnt + 1'b1 : '0;
    end

    always_comb begin
        pc_stall      = !rst && (mem_wait || load_use);
        if_id_stall   = !rst && (mem_wait || load_use);
        if_id_flush   = rst || jump;
        id_exe_stall  = !rst && mem_wait;
        id_exe_flush  = rst || jump || load_use;
        exe_mem_stall = !rst && mem_wait;
        exe_mem_flush = rst;
        mem_wb_flush  = rst || mem_wait || timeout;
        pc_jump_sel   = !rst && jump;
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (pc_jump_sel && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, exe_rd_addr = '0;
    logic        id_rs1_used = 0, id_rs2_used = 0, exe_mem_read = 0, exe_jump_taken = 0;
    logic        dmem_req = 0, dmem_ready = 0;
    logic        pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
    logic        exe_mem_stall, exe_mem_flush, mem_wb_flush, pc_jump_sel, mem_timeout_err;
    logic [31:0] stall_cycles, flush_events;
    logic [9:0]  ctl, got, e;
    logic [9:0]  sb[$];
    int          compared = 0, mismatched = 0;

    // {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_stall, exe_mem_flush, mem_wb_flush, pc_jump_sel, mem_timeout_err}
    localparam logic [9:0] IDLE = 10'b0000000000;
    localparam logic [9:0] RSTV = 10'b0010101100;
    localparam logic [9:0] LU   = 10'b1100100000;
    localparam logic [9:0] JMP  = 10'b0010100010;
    localparam logic [9:0] MW   = 10'b1101010100;
    localparam logic [9:0] TO   = 10'b0000000100;
    localparam logic [9:0] ERR  = 10'b0000000001;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush,
                  exe_mem_stall, exe_mem_flush, mem_wb_flush, pc_jump_sel, mem_timeout_err};

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd_addr(exe_rd_addr), .exe_mem_read(exe_mem_read),
        .exe_jump_taken(exe_jump_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
        .exe_mem_stall(exe_mem_stall), .exe_mem_flush(exe_mem_flush),
        .mem_wb_flush(mem_wb_flush), .pc_jump_sel(pc_jump_sel),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic r, u1, u2, mr, j, rq, rdy,
                                       input logic [4:0] rd, r1, r2);
        return {r, u1, u2, mr, j, rq, rdy, rd, r1, r2};
    endfunction

    task automatic drive(input logic [21:0] s);
        {rst, id_rs1_used, id_rs2_used, exe_mem_read, exe_jump_taken, dmem_req, dmem_ready,
         exe_rd_addr, id_rs1_addr, id_rs2_addr} = s;
    endtask

    task automatic test_reset;
        logic [21:0] st [8];
        logic [9:0]  ex [8];
        st = '{mk(1,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0),
               mk(1,0,0,0,1,1,0,0,0,0), mk(1,0,0,0,1,1,0,0,0,0), mk(1,1,0,1,1,1,0,5,5,0),
               mk(0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{RSTV, MW, MW, RSTV, RSTV, RSTV, IDLE, IDLE};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %b want %b", i, got, e);
            end
        end
    endtask

    task automatic test_load_use;
        logic [21:0] st [7];
        logic [9:0]  ex [7];
        st = '{mk(0,1,0,1,0,0,0,5,5,0), mk(0,1,0,0,0,0,0,0,5,0), mk(0,1,0,1,0,0,0,0,0,0),
               mk(0,0,0,1,0,0,0,5,5,0), mk(0,0,1,1,0,0,0,7,0,7), mk(0,1,1,1,0,0,0,6,5,7),
               mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{LU, IDLE, IDLE, IDLE, LU, IDLE, IDLE};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL load_use[%0d]: got %b want %b", i, got, e);
            end
        end
    endtask

    task automatic test_jump_priority;
        logic [21:0] st [3];
        logic [9:0]  ex [3];
        st = '{mk(0,1,0,1,1,0,0,5,5,0), mk(0,0,0,0,1,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{JMP, JMP, IDLE};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL jump_priority[%0d]: got %b want %b", i, got, e);
            end
        end
    endtask

    task automatic test_mem_wait;
        logic [21:0] st [10];
        logic [9:0]  ex [10];
        st = '{mk(0,0,0,0,1,1,0,0,0,0), mk(0,0,0,0,1,1,0,0,0,0), mk(0,0,0,0,1,1,0,0,0,0),
               mk(0,0,0,0,1,1,1,0,0,0), mk(0,0,0,0,0,0,0,0,0,0), mk(0,1,0,1,0,1,0,3,3,0),
               mk(0,1,0,1,0,1,0,3,3,0), mk(0,1,0,1,0,1,1,3,3,0), mk(0,0,0,0,0,1,1,0,0,0),
               mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{MW, MW, MW, JMP, IDLE, MW, MW, LU, IDLE, IDLE};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, got, e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [21:0] st [10];
        logic [9:0]  ex [10];
        st = '{mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0),
               mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0),
               mk(0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0,0),
               mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{MW, MW, MW, MW, TO, MW | ERR, ERR, ERR, RSTV, IDLE};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL timeout[%0d]: got %b want %b", i, got, e);
            end
        end
    endtask

    task automatic test_perf;
        logic [21:0] st [8];
        logic [9:0]  ex [8];
        logic [31:0] want_stall, want_flush;
`ifdef HAZ_PERF_CNT_EN
        want_stall = 32'd4;
        want_flush = 32'd1;
`else
        want_stall = 32'd0;
        want_flush = 32'd0;
`endif
        st = '{mk(1,0,0,0,0,0,0,0,0,0), mk(0,1,0,1,0,0,0,5,5,0), mk(0,1,0,0,0,0,0,0,5,0),
               mk(0,0,0,0,1,1,0,0,0,0), mk(0,0,0,0,1,1,0,0,0,0), mk(0,0,0,0,1,1,0,0,0,0),
               mk(0,0,0,0,1,1,1,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{RSTV, LU, IDLE, MW, MW, MW, JMP, IDLE};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk); got = ctl; e = sb.pop_front(); compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL perf_seq[%0d]: got %b want %b", i, got, e);
            end
        end
        @(posedge clk); #1;
        compared++;
        if (stall_cycles !== want_stall) begin
            mismatched++;
            $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, want_stall);
        end
        compared++;
        if (flush_events !== want_flush) begin
            mismatched++;
            $display("FAIL flush_events: got %0d want %0d", flush_events, want_flush);
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_jump_priority;
        test_mem_wait;
        test_timeout;
        test_perf;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EXE/MEM/WB). It merges load-use hazards, taken jumps/branches resolved in EXE, and multi-cycle data-memory waits into per-register stall and flush controls. It also generates the jump-select for the PC mux. A small FSM with a wait counter bounds memory stalls and flags a timeout.

Parameters:
REG_ADDR_W, 5, register-file address width
MEM_TIMEOUT, 15, max consecutive MEM-wait stall cycles before forced release (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
id_rs1_addr  input  REG_ADDR_W  rs1 of instruction in ID
id_rs2_addr  input  REG_ADDR_W  rs2 of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
exe_rd_addr  input  REG_ADDR_W  rd of instruction in EXE
exe_mem_read  input  1  EXE instruction is a load
exe_jump_taken  input  1  EXE resolved a taken branch/jump
dmem_req  input  1  MEM stage has an active data access
dmem_ready  input  1  data memory completes access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  bubble IF/ID
id_exe_stall  output  1  hold ID/EXE
id_exe_flush  output  1  bubble ID/EXE
exe_mem_stall  output  1  hold EXE/MEM
exe_mem_flush  output  1  bubble EXE/MEM
mem_wb_flush  output  1  bubble MEM/WB
pc_jump_sel  output  1  PC loads EXE jump target
mem_timeout_err  output  1  sticky memory-timeout flag
stall_cycles  output  32  perf: stalled cycles (optional feature)
flush_events  output  32  perf: jump flush events (optional feature)

Behaviour:
- States: RUN, MEM_WAIT. Registered: state, wait_cnt (width clog2(MEM_TIMEOUT+1)), mem_timeout_err. Controls are Mealy: decoded combinationally from state and current inputs, so they take effect in the same cycle.
- rst asserted: state=RUN, wait_cnt=0, mem_timeout_err=0. All four *_flush=1; all stalls, pc_jump_sel and perf counters are 0. Reset mid-MEM_WAIT aborts the wait immediately.
- Default (no event): all controls 0.
- Priority, high to low: rst > memory wait > jump > load-use.
- Memory wait (RUN or MEM_WAIT, dmem_req=1, dmem_ready=0, not timed out):
  - pc_stall, if_id_stall, id_exe_stall, exe_mem_stall = 1; mem_wb_flush = 1.
  - Jump and load-use are suppressed. Both are re-evaluated once the wait ends, because EXE/ID are held.
  - RUN->MEM_WAIT with wait_cnt=1. In MEM_WAIT, wait_cnt increments each stalled cycle.
- In MEM_WAIT with dmem_ready=1: no stall that cycle, ->RUN, wait_cnt=0. Jump and load-use decode apply normally in that cycle.
- Timeout: in MEM_WAIT with wait_cnt==MEM_TIMEOUT and dmem_ready=0:
  - No stall; mem_wb_flush=1 (the load result is discarded).
  - ->RUN, wait_cnt=0, mem_timeout_err set at the next edge and held until rst.
  - Result: at most MEM_TIMEOUT consecutive stall cycles.
- Jump (exe_jump_taken=1, no memory wait): pc_jump_sel=1, if_id_flush=1, id_exe_flush=1; no stall.
- Load-use (no memory wait, no jump): asserted when exe_mem_read=1, exe_rd_addr!=0, and either:
  - id_rs1_used and id_rs1_addr==exe_rd_addr, or
  - id_rs2_used and id_rs2_addr==exe_rd_addr.
  - Response: pc_stall=1, if_id_stall=1, id_exe_flush=1 for exactly one cycle. The following cycle has a bubble in EXE, so the hazard self-clears.
- Loads to x0 never stall.
- A stall and a flush are never both asserted on the same register.
- exe_mem_flush is 1 only during rst.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments (saturating at 2^32-1) in every cycle pc_stall=1.
  - flush_events increments (saturating) in every cycle pc_jump_sel=1.
  - Both counters clear on rst.
- Undefined: both ports are present and tied to 0, and no counter flops exist.

Test Plan:
- rst=1 for 3 cycles, mid-stream -> all *_flush=1, stalls=0, mem_timeout_err=0. After release, all controls 0 with idle inputs.
- exe_mem_read=1, exe_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 -> one cycle of pc_stall/if_id_stall/id_exe_flush=1; next cycle (EXE bubble) all 0. Same with exe_rd_addr=0 -> no stall.
- Load-use condition plus exe_jump_taken=1 in the same cycle -> pc_jump_sel=if_id_flush=id_exe_flush=1, pc_stall=0.
- dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles of the four stalls with mem_wb_flush=1, release on the 4th, state RUN; exe_jump_taken held throughout -> pc_jump_sel=1 only in the release cycle.
- MEM_TIMEOUT=4, dmem_req=1, dmem_ready=0 forever -> 4 stall cycles; 5th cycle no stall with mem_wb_flush=1; mem_timeout_err=1 from the next edge and held until rst.
- With HAZ_PERF_CNT_EN defined, run the load-use and memory-wait cases above -> stall_cycles=4, and flush_events=1 after one jump.
